// File: rtl/tx_packet_buf_pkg.sv
// Shared definitions for the TX packet buffer: FSM states, status bit positions
// and preamble constants. The preamble is only used when TX_BUF_PREAMBLE_EN is defined.
package tx_packet_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Bit positions inside the status byte {busy, full, empty, ovf, unf, done, 2'b00}
  localparam int STAT_BUSY  = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_OVF   = 4;
  localparam int STAT_UNF   = 3;
  localparam int STAT_DONE  = 2;

  localparam logic [1:0] PREAMBLE_SYM = 2'b01;
  localparam int         PREAMBLE_LEN = 16;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with extra-MSB pointers so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_q[AW-1:0]];

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; reset empties the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_packet_buf.sv
// TX packet buffer: bytes pushed by the register decoder are serialised into
// 2-bit symbols (MSB pair first) with a valid/ready handshake.
// Optional feature macro: TX_BUF_PREAMBLE_EN (sends 16 x 2'b01 before the payload).
module tx_packet_buf
  import tx_packet_buf_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       len_wr_en,
  input  logic [7:0] len_in,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       sym_valid,
  output logic [1:0] sym,
  input  logic       sym_rdy
);

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;
  logic       sym_valid_q, sym_valid_d;
  logic       ovf_q, ovf_d, unf_q, unf_d, done_q, done_d;
  logic [7:0] data_out_q, data_out_d;
`ifdef TX_BUF_PREAMBLE_EN
  logic [3:0] pre_cnt_q, pre_cnt_d;
`endif

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       xfer, busy;
  logic [7:0] status;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .pop     (fifo_pop),
    .din     (data_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop  = (state_q == ST_LOAD);
  assign xfer      = sym_valid_q && sym_rdy;
  assign busy      = (state_q != ST_IDLE);
  assign sym_valid = sym_valid_q;
  assign sym       = shreg_q[7:6];
  assign data_out  = data_out_q;

  // Status snapshot taken on a register read
  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = busy;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = ovf_q;
    status[STAT_UNF]   = unf_q;
    status[STAT_DONE]  = done_q;
  end

  // FSM next state, shifter and sticky flags; a same-cycle set beats the read clear
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sym_valid_d = sym_valid_q;
`ifdef TX_BUF_PREAMBLE_EN
    pre_cnt_d   = pre_cnt_q;
`endif
    ovf_d       = (ovf_q  && !rd_en) || (wr_en && fifo_full && !fifo_pop);
    unf_d       = (unf_q  && !rd_en) || (state_q == ST_LOAD && fifo_empty);
    done_d      = (done_q && !rd_en) || (state_q == ST_DONE);
    data_out_d  = rd_en ? status : data_out_q;

    case (state_q)
      ST_IDLE: begin
        if (len_wr_en && len_in != 8'd0) begin
          len_d = len_in;
`ifdef TX_BUF_PREAMBLE_EN
          state_d     = ST_PRE;
          shreg_d     = {4{PREAMBLE_SYM}};
          sym_valid_d = 1'b1;
          pre_cnt_d   = 4'(PREAMBLE_LEN - 1);
`else
          state_d = ST_LOAD;
`endif
        end
      end
`ifdef TX_BUF_PREAMBLE_EN
      ST_PRE: begin
        if (xfer) begin
          if (pre_cnt_q == 4'd0) begin
            state_d     = ST_LOAD;
            sym_valid_d = 1'b0;
            shreg_d     = 8'h00;
          end else begin
            pre_cnt_d = pre_cnt_q - 4'd1;
          end
        end
      end
`endif
      ST_LOAD: begin
        // An empty FIFO still yields a byte (zeros) so the packet keeps its length
        shreg_d     = fifo_empty ? 8'h00 : fifo_dout;
        cnt_d       = 2'd3;
        len_d       = len_q - 8'd1;
        sym_valid_d = 1'b1;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (xfer) begin
          shreg_d = {shreg_q[5:0], 2'b00};
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end else begin
            sym_valid_d = 1'b0;
            state_d     = (len_q != 8'd0) ? ST_LOAD : ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sym_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      done_q      <= 1'b0;
      data_out_q  <= '0;
`ifdef TX_BUF_PREAMBLE_EN
      pre_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sym_valid_q <= sym_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      done_q      <= done_d;
      data_out_q  <= data_out_d;
`ifdef TX_BUF_PREAMBLE_EN
      pre_cnt_q   <= pre_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_packet_buf.sv
// Scoreboard bench for tx_packet_buf: stimulus queues expected symbols and
// status bytes; a negedge monitor pops and compares them as the DUT emits.
module tb_tx_packet_buf;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       len_wr_en = 1'b0;
  logic [7:0] len_in = '0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_rdy = 1'b1;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_sym[$];
  logic [7:0] exp_stat[$];
  logic       rd_seen = 1'b0;
  logic       hold_prev = 1'b0;
  logic [1:0] hold_sym = '0;
  logic       rnd_en = 1'b0;

  tx_packet_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .len_wr_en (len_wr_en),
    .len_in    (len_in),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_rdy   (sym_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1; data_in = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_sym.push_back(b[7:6]);
    exp_sym.push_back(b[5:4]);
    exp_sym.push_back(b[3:2]);
    exp_sym.push_back(b[1:0]);
  endtask

  task automatic exp_pre();
`ifdef TX_BUF_PREAMBLE_EN
    for (int i = 0; i < 16; i++) exp_sym.push_back(2'b01);
`endif
  endtask

  task automatic start(input logic [7:0] n);
    len_wr_en = 1'b1; len_in = n;
    tick();
    len_wr_en = 1'b0;
  endtask

  task automatic read_status(input logic [7:0] exp);
    exp_stat.push_back(exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  // Wait for all queued symbols to be sent, then let DONE retire
  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_sym.size() != 0 && k < budget) begin tick(); k++; end
    n_tests++;
    if (exp_sym.size() != 0) begin
      n_fail++;
      $display("FAIL %s: timeout, %0d symbols still expected", name, exp_sym.size());
      exp_sym.delete();
    end
    repeat (4) tick();
  endtask

  always @(posedge clk) rd_seen <= rd_en && reset_n;

  // Random backpressure while enabled
  always @(posedge clk) begin
    #1;
    if (rnd_en) sym_rdy = 1'($urandom_range(0, 1));
  end

  // Monitor: symbol stability under backpressure, symbol and status scoreboards
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold_prev) begin
        n_tests++;
        if (!(sym_valid && sym == hold_sym)) begin
          n_fail++;
          $display("FAIL sym_hold: got valid=%0b sym=%0d expected valid=1 sym=%0d", sym_valid, sym, hold_sym);
        end
      end
      hold_prev = sym_valid && !sym_rdy;
      hold_sym  = sym;
      if (sym_valid && sym_rdy) begin
        if (exp_sym.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sym_extra: got sym=%0d expected no symbol", sym);
        end else begin
          chk("sym", {6'd0, sym}, {6'd0, exp_sym.pop_front()});
        end
      end
      if (rd_seen) begin
        if (exp_stat.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL status_extra: got %h expected no read", data_out);
        end else begin
          chk("status", data_out, exp_stat.pop_front());
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0;
    repeat (2) tick();
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_sym_valid", {7'd0, sym_valid}, 8'h00);
    chk("rst_sym", {6'd0, sym}, 8'h00);
    reset_n = 1'b1;
    tick();
    read_status(8'h20);

    // Basic packet: A5, 3C -> 2,2,1,1,0,3,3,0; stray len write mid-packet ignored
    push(8'hA5); push(8'h3C);
    exp_pre(); exp_byte(8'hA5); exp_byte(8'h3C);
    start(8'd2);
`ifndef TX_BUF_PREAMBLE_EN
    chk("first_valid_lat1", {7'd0, sym_valid}, 8'h00);
    tick();
    chk("first_valid_lat2", {7'd0, sym_valid}, 8'h01);
`endif
    tick();
    start(8'd5);
    drain("basic", 200);
    read_status(8'h24);
    read_status(8'h20);

    // Overflow: DEPTH+1 pushes, last one dropped
    for (int i = 0; i <= DEPTH; i++) push(8'h10 + 8'(i));
    read_status(8'h50);
    read_status(8'h40);
    exp_pre();
    for (int i = 0; i < DEPTH; i++) exp_byte(8'h10 + 8'(i));
    start(8'(DEPTH));
    drain("ovf_pkt", 400);
    read_status(8'h24);

    // Underflow: second byte comes out as zeros
    push(8'h81);
    exp_pre(); exp_byte(8'h81); exp_byte(8'h00);
    start(8'd2);
    drain("unf_pkt", 200);
    read_status(8'h2C);

    // Random backpressure on a 3-byte packet
    push(8'h1B); push(8'hE4); push(8'h96);
    exp_pre(); exp_byte(8'h1B); exp_byte(8'hE4); exp_byte(8'h96);
    rnd_en = 1'b1;
    start(8'd3);
    drain("rnd_pkt", 600);
    rnd_en = 1'b0;
    sym_rdy = 1'b1;
    tick();
    read_status(8'h24);

    // Asynchronous reset mid-packet
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    exp_pre(); exp_byte(8'h11); exp_byte(8'h22); exp_byte(8'h33); exp_byte(8'h44);
    start(8'd4);
    repeat (6) tick();
    #1;
    reset_n = 1'b0;
    exp_sym.delete();
    #1;
    chk("arst_sym_valid", {7'd0, sym_valid}, 8'h00);
    chk("arst_sym", {6'd0, sym}, 8'h00);
    chk("arst_data_out", data_out, 8'h00);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_quiet", {7'd0, sym_valid}, 8'h00);
    read_status(8'h20);

    // Single 0xFF byte (preceded by preamble when enabled)
    push(8'hFF);
    exp_pre(); exp_byte(8'hFF);
    start(8'd1);
    drain("ff_pkt", 200);
    read_status(8'h24);

    repeat (3) tick();
    chk("sym_queue_left", 8'(exp_sym.size()), 8'h00);
    chk("stat_queue_left", 8'(exp_stat.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
